step_pulse_gen: RTL and testbench

//  Initiator side of the processor single-step interface: generates the Step pulses

---
 rtl/step_pulse_gen.sv | 125 ++++++++++++
 tb/tb_step_pulse_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_gen.sv
// Single-step pulse initiator: debounced pushbutton and periodic auto-step
// produce one-cycle Step pulses, counted and optionally capped at STEP_LIMIT.
module step_pulse_gen #(
    parameter int DB_CYCLES   = 16,
    parameter int AUTO_PERIOD = 11,
    parameter int STEP_LIMIT  = 256,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_in,
    input  logic             auto_en,
    output logic             Step,
    output logic [CNT_W-1:0] step_count,
    output logic             busy,
    output logic             done
);

    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int P_W  = $clog2(AUTO_PERIOD);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [P_W-1:0]   P_LAST   = P_W'(AUTO_PERIOD - 1);
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STEP_LIMIT);
    localparam bit               LIMIT_EN = (STEP_LIMIT != 0);

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        FIRE,
        HELD,
        RELEASE
    } state_e;

    state_e            state_q, state_d;
    logic [DB_W-1:0]   dbcnt_q, dbcnt_d;
    logic [1:0]        sync_q;
    logic              btn_s;
    logic [P_W-1:0]    pcnt_q, pcnt_d;
    logic [CNT_W-1:0]  count_q, count_d, count_inc;
    logic              done_q, done_d;
    logic              step_prev_q;
    logic              manual_fire;
    logic              auto_fire;

    assign btn_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dbcnt_q <= '0;
        end else begin
            state_q <= state_d;
            dbcnt_q <= dbcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dbcnt_d = dbcnt_q;
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS;
                    dbcnt_d = '0;
                end
            end
            PRESS: begin
                if (!btn_s)                  state_d = IDLE;
                else if (dbcnt_q == DB_LAST) state_d = FIRE;
                else                         dbcnt_d = dbcnt_q + 1'b1;
            end
            FIRE: state_d = HELD;
            HELD: begin
                if (!btn_s) begin
                    state_d = RELEASE;
                    dbcnt_d = '0;
                end
            end
            RELEASE: begin
                if (btn_s)                   state_d = HELD;
                else if (dbcnt_q == DB_LAST) state_d = IDLE;
                else                         dbcnt_d = dbcnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // A request landing on the cycle right after a pulse merges into that pulse,
    // so Step can never be high on two consecutive cycles.
    always_comb begin
        manual_fire = (state_q == FIRE);
        busy        = (state_q != IDLE);
        auto_fire   = auto_en && !done_q && (pcnt_q == P_LAST);
        Step        = (manual_fire || auto_fire) && !done_q && !step_prev_q;
    end

    always_comb begin
        count_inc = count_q + 1'b1;
        count_d   = Step ? count_inc : count_q;
        done_d    = done_q || (LIMIT_EN && Step && (count_inc == LIMIT));
        if (!auto_en || done_q)  pcnt_d = '0;
        else if (pcnt_q == P_LAST) pcnt_d = '0;
        else                     pcnt_d = pcnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '0;
            pcnt_q      <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], btn_in};
            pcnt_q      <= pcnt_d;
            count_q     <= count_d;
            done_q      <= done_d;
            step_prev_q <= Step;
        end
    end

    assign step_count = count_q;
    assign done       = done_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: one unlimited instance and one capped at five
// steps share the same button/auto stimulus.
module tb_step_pulse_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        btnIn;
    logic        autoEn;
    logic        stepU, stepL;
    logic [15:0] countU, countL;
    logic        busyU, busyL;
    logic        doneU, doneL;

    int errors = 0;
    int checks = 0;
    bit monOn = 1'b0;
    logic prevStepU = 1'b0;
    logic prevStepL = 1'b0;

    step_pulse_gen #(.DB_CYCLES(4), .AUTO_PERIOD(11), .STEP_LIMIT(0), .CNT_W(16)) dutU (
        .clk(clk), .rst(rst), .btn_in(btnIn), .auto_en(autoEn),
        .Step(stepU), .step_count(countU), .busy(busyU), .done(doneU)
    );

    step_pulse_gen #(.DB_CYCLES(4), .AUTO_PERIOD(11), .STEP_LIMIT(5), .CNT_W(16)) dutL (
        .clk(clk), .rst(rst), .btn_in(btnIn), .auto_en(autoEn),
        .Step(stepL), .step_count(countL), .busy(busyL), .done(doneL)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic b, input logic a);
        btnIn  = b;
        autoEn = a;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    // Step must never stay high across two consecutive cycles on either instance.
    always @(negedge clk) begin
        if (monOn) begin
            checkOutput("adjacent_stepU", 32'(prevStepU && stepU), 32'd0);
            checkOutput("adjacent_stepL", 32'(prevStepL && stepL), 32'd0);
        end
        prevStepU = stepU;
        prevStepL = stepL;
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        tick(2);
        checkOutput("rst_step",  32'(stepL),  32'd0);
        checkOutput("rst_count", 32'(countL), 32'd0);
        checkOutput("rst_busy",  32'(busyL),  32'd0);
        checkOutput("rst_done",  32'(doneL),  32'd0);
        monOn = 1'b1;
        rst = 1'b0;

        // Clean press: FIRE seven edges after the rise, one count, release debounced.
        applyStimulus(1'b1, 1'b0);
        tick(6);
        checkOutput("press_early_step", 32'(stepL), 32'd0);
        checkOutput("press_busy",       32'(busyL), 32'd1);
        tick(1);
        checkOutput("press_fire_step",  32'(stepL),  32'd1);
        checkOutput("press_fire_count", 32'(countL), 32'd0);
        tick(1);
        checkOutput("press_after_step", 32'(stepL),  32'd0);
        checkOutput("press_count",      32'(countL), 32'd1);
        tick(12);
        checkOutput("press_held_count", 32'(countL), 32'd1);
        applyStimulus(1'b0, 1'b0);
        tick(6);
        checkOutput("release_busy", 32'(busyL), 32'd1);
        tick(1);
        checkOutput("release_idle", 32'(busyL),  32'd0);
        checkOutput("release_count", 32'(countL), 32'd1);

        // Bounce: short pulses are rejected, a long hold gives exactly one step.
        doReset();
        applyStimulus(1'b1, 1'b0); tick(2);
        applyStimulus(1'b0, 1'b0); tick(1);
        applyStimulus(1'b1, 1'b0); tick(2);
        applyStimulus(1'b0, 1'b0); tick(8);
        checkOutput("bounce_count", 32'(countL), 32'd0);
        checkOutput("bounce_busy",  32'(busyL),  32'd0);
        applyStimulus(1'b1, 1'b0); tick(10);
        checkOutput("hold_count", 32'(countL), 32'd1);
        checkOutput("hold_busy",  32'(busyL),  32'd1);
        applyStimulus(1'b0, 1'b0); tick(8);
        checkOutput("hold_release_count", 32'(countL), 32'd1);
        checkOutput("hold_release_busy",  32'(busyL),  32'd0);

        // Auto mode: pulses every 11 cycles; the capped instance stops after five.
        doReset();
        applyStimulus(1'b0, 1'b1);
        for (int p = 1; p <= 5; p++) begin
            tick(9);
            checkOutput("auto_gapU", 32'(stepU), 32'd0);
            tick(1);
            checkOutput("auto_stepU", 32'(stepU), 32'd1);
            checkOutput("auto_stepL", 32'(stepL), 32'd1);
            checkOutput("auto_doneL_before", 32'(doneL), 32'd0);
            tick(1);
            checkOutput("auto_offU",   32'(stepU),  32'd0);
            checkOutput("auto_countU", 32'(countU), 32'(p));
            checkOutput("auto_countL", 32'(countL), 32'(p));
            checkOutput("auto_doneL",  32'(doneL),  32'(p == 5));
            checkOutput("auto_doneU",  32'(doneU),  32'd0);
        end
        tick(10);
        checkOutput("auto_sixthU",   32'(stepU), 32'd1);
        checkOutput("limit_nostepL", 32'(stepL), 32'd0);
        tick(1);
        checkOutput("auto_countU6",  32'(countU), 32'd6);
        checkOutput("limit_countL",  32'(countL), 32'd5);
        applyStimulus(1'b1, 1'b0); tick(20);
        applyStimulus(1'b0, 1'b0); tick(8);
        checkOutput("limit_press_countL", 32'(countL), 32'd5);
        checkOutput("limit_press_doneL",  32'(doneL),  32'd1);
        checkOutput("manual_countU7",     32'(countU), 32'd7);

        // Collision: manual FIRE lands on the same cycle as the auto pulse.
        doReset();
        applyStimulus(1'b0, 1'b1); tick(3);
        applyStimulus(1'b1, 1'b1); tick(6);
        checkOutput("collide_pre_step", 32'(stepL), 32'd0);
        tick(1);
        checkOutput("collide_stepL", 32'(stepL), 32'd1);
        checkOutput("collide_stepU", 32'(stepU), 32'd1);
        tick(1);
        checkOutput("collide_offL",   32'(stepL),  32'd0);
        checkOutput("collide_countL", 32'(countL), 32'd1);
        checkOutput("collide_countU", 32'(countU), 32'd1);
        applyStimulus(1'b0, 1'b0); tick(10);
        checkOutput("collide_after_countL", 32'(countL), 32'd1);

        // Reset mid-press with the period counter at 9.
        applyStimulus(1'b0, 1'b1); tick(4);
        applyStimulus(1'b1, 1'b1); tick(5);
        checkOutput("midpress_busy", 32'(busyL), 32'd1);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1);
        tick(1);
        checkOutput("midrst_step",   32'(stepL),  32'd0);
        checkOutput("midrst_countL", 32'(countL), 32'd0);
        checkOutput("midrst_countU", 32'(countU), 32'd0);
        checkOutput("midrst_busy",   32'(busyL),  32'd0);
        checkOutput("midrst_done",   32'(doneL),  32'd0);
        rst = 1'b0;
        tick(9);
        checkOutput("post_rst_gap",  32'(stepU), 32'd0);
        tick(1);
        checkOutput("post_rst_auto", 32'(stepU), 32'd1);
        tick(1);
        checkOutput("post_rst_count", 32'(countU), 32'd1);

        applyStimulus(1'b0, 1'b0);
        monOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
